// File: rtl/mul_32_seq_if.sv
// Handshake and result bus for the sequential 32x32 signed multiplier.
// master: control unit (drives request/operands); slave: the multiplier.
interface mul_32_seq_if;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    modport master (
        output start, multiplicand, multiplier,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mul_32_seq.sv
// mul_32_seq: iterative Booth-recoded 32x32 signed multiplier, 64-bit product
// returned as hi/lo. Configuration macro MUL32_BOOTH_RADIX4_EN selects
// radix-4 modified Booth (16 steps); default build is radix-2 Booth (32 steps).
// Handshake: start accepted in IDLE, busy for N cycles, one-cycle done pulse.
module mul_32_seq (
    input  logic        clk,
    input  logic        clr,
    mul_32_seq_if.slave bus
);

`ifdef MUL32_BOOTH_RADIX4_EN
    localparam int N  = 16;
    localparam int SH = 2;
    localparam int AW = 34;
`else
    localparam int N  = 32;
    localparam int SH = 1;
    localparam int AW = 33;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nxt;

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] m_ext;
    logic        [31:0]   q;
    logic                 guard;
    logic        [5:0]    cnt;
    logic        [31:0]   prod_hi;
    logic        [31:0]   prod_lo;

    logic signed [AW-1:0] addend;
    logic signed [AW-1:0] sum;
    logic signed [AW+32:0] wide;
    logic signed [AW+32:0] shifted;
    logic signed [AW-1:0] acc_nxt;
    logic        [31:0]   q_nxt;
    logic                 guard_nxt;
    logic                 last_step;

    // Booth step: recode low Q bits + guard, add partial product, arithmetic shift
    always_comb begin
        addend = '0;
`ifdef MUL32_BOOTH_RADIX4_EN
        case ({q[1:0], guard})
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m_ext <<< 1;
            3'b100:         addend = -(m_ext <<< 1);
            3'b101, 3'b110: addend = -m_ext;
            default:        addend = '0;
        endcase
`else
        case ({q[0], guard})
            2'b01:   addend = m_ext;
            2'b10:   addend = -m_ext;
            default: addend = '0;
        endcase
`endif
        sum     = acc + addend;
        wide    = {sum, q, guard};
        shifted = wide >>> SH;
    end

    assign acc_nxt   = shifted[AW+32:33];
    assign q_nxt     = shifted[32:1];
    assign guard_nxt = shifted[0];
    assign last_step = (cnt == 6'd1);

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: start only matters in IDLE; DONE always falls back to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load operands on accept, step in RUN, capture product on last step
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            acc     <= '0;
            m_ext   <= '0;
            q       <= '0;
            guard   <= 1'b0;
            cnt     <= '0;
            prod_hi <= '0;
            prod_lo <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        m_ext <= {{(AW-32){bus.multiplicand[31]}}, bus.multiplicand};
                        q     <= bus.multiplier;
                        acc   <= '0;
                        guard <= 1'b0;
                        cnt   <= 6'(N);
                    end
                end
                RUN: begin
                    acc   <= acc_nxt;
                    q     <= q_nxt;
                    guard <= guard_nxt;
                    cnt   <= cnt - 6'd1;
                    // Exact product fits in 64 bits, so upper accumulator bits are sign copies
                    if (last_step) begin
                        prod_hi <= acc_nxt[31:0];
                        prod_lo <= q_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi   = prod_hi;
    assign bus.lo   = prod_lo;
    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);

endmodule
